// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter (and the planned receiver).
// Holds the parity mode encodings and the transmit FSM state type.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate tick generator.
// A free-running phase accumulator adds BAUD every cycle and wraps modulo
// CLK_HZ; every wrap produces a one-cycle tick, so the long-run tick rate is
// exactly BAUD with no cumulative drift.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (accumulator cleared to 0)
//   tick_o  one-cycle pulse, BAUD pulses per CLK_HZ cycles on average
module uart_baud_gen #(
    parameter int CLK_HZ = 70000000,
    parameter int BAUD   = 115200
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int AW = $clog2(CLK_HZ) + 1;
    localparam logic [AW:0] BAUD_W = (AW+1)'(BAUD);
    localparam logic [AW:0] CLK_W  = (AW+1)'(CLK_HZ);

    logic [AW-1:0] acc_q, acc_d;
    logic [AW:0]   sum;
    logic          tick;

    always_comb begin
        sum = {1'b0, acc_q} + BAUD_W;
        if (sum >= CLK_W) begin
            acc_d = AW'(sum - CLK_W);
            tick  = 1'b1;
        end else begin
            acc_d = sum[AW-1:0];
            tick  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Tick depends only on the accumulator register, never on inputs.
    assign tick_o = tick;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered, parametrised UART transmitter for console/debug output.
// Bytes written by the store unit are queued in a circular FIFO and sent
// LSB-first as start + DATA_BITS + optional parity + STOP_BITS frames.
// Queued bytes are sent back-to-back with no idle gap between frames.
// Ports:
//   sys_clk_i     system clock
//   sys_rstn_i    asynchronous active-low reset; aborts any frame, empties FIFO
//   uart_wr_i     write strobe, one word pushed per cycle while high
//   uart_dat_i    word to push
//   uart_full_o   FIFO full (registered); writes while high are dropped
//   uart_empty_o  FIFO empty (registered)
//   uart_level_o  FIFO occupancy (registered)
//   uart_ovf_o    one-cycle pulse per dropped write
//   uart_busy_o   frame on the line or FIFO non-empty
//   uart_tx       serial line, idle high (registered)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 70000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rstn_i,
    input  logic                          uart_wr_i,
    input  logic [DATA_BITS-1:0]          uart_dat_i,
    output logic                          uart_full_o,
    output logic                          uart_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
    output logic                          uart_ovf_o,
    output logic                          uart_busy_o,
    output logic                          uart_tx
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          STOP_INIT = (STOP_BITS == 2);

    if (BAUD < 1 || BAUD > CLK_HZ / 2) begin : g_bad_baud
        $error("uart_tx_fifo: BAUD must be in 1..CLK_HZ/2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic tick;

    uart_baud_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud_gen (
        .clk_i  (sys_clk_i),
        .rst_ni (sys_rstn_i),
        .tick_o (tick)
    );

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        level_q, level_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    // Transmit FSM
    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 load;

    // Full is the registered pre-pop flag, so a pop in the same cycle does
    // not make room for a concurrent write.
    assign push = uart_wr_i && !full_q;
    assign head = mem_q[rd_ptr_q[PW-2:0]];

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-2:0]] <= uart_dat_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        load       = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    load = !empty_q;
                end
                START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = LAST_BIT;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q == '0) begin
                        if (PARITY != PAR_NONE) begin
                            tx_d    = par_q;
                            state_d = PAR;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = STOP_INIT;
                            state_d    = STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - CW'(1);
                    end
                end
                PAR: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = STOP_INIT;
                    state_d    = STOP;
                end
                STOP: begin
                    if (stop_cnt_q) begin
                        stop_cnt_d = 1'b0;
                    end else if (!empty_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end

        // Shared by IDLE and back-to-back STOP: pop the head, latch its
        // parity and start driving the start bit.
        if (load) begin
            shift_d = head;
            par_d   = (PARITY == PAR_ODD) ? ~(^head) : ^head;
            tx_d    = 1'b0;
            state_d = START;
        end
        pop = load;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (level_d == PW'(FIFO_DEPTH));
        empty_d  = (level_d == '0);
        ovf_d    = uart_wr_i && full_q;
        busy_d   = (state_d != IDLE) || !empty_d;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    assign uart_full_o  = full_q;
    assign uart_empty_o = empty_q;
    assign uart_level_o = level_q;
    assign uart_ovf_o   = ovf_q;
    assign uart_busy_o  = busy_q;
    assign uart_tx      = tx_q;

endmodule
